// File: rtl/esp8266_at_sequencer_pkg.sv
// Shared definitions for the ESP8266 AT command sequencer:
// FSM encoding, UART response byte constants and command-set sizing.
package esp8266_at_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_TX,
        ST_WAIT_RSP,
        ST_NEXT,
        ST_DONE,
        ST_FAIL
    } state_t;

    localparam logic [7:0] CH_O      = 8'h4F;
    localparam logic [7:0] CH_K      = 8'h4B;
    localparam logic [7:0] CH_R      = 8'h52;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_PROMPT = 8'h3E;
    localparam logic [7:0] CH_END    = 8'h00;

    // Four-byte windows compared against the most recent received bytes.
    localparam logic [31:0] RSP_OK  = {CH_O, CH_K, CH_CR, CH_LF};
    localparam logic [31:0] RSP_ERR = {CH_O, CH_R, CH_CR, CH_LF};

    localparam int         NUM_STEPS   = 5;
    localparam logic [2:0] LAST_STEP   = 3'(NUM_STEPS - 1);
    localparam int         MAX_CMD_LEN = 64;

endpackage

// File: rtl/esp8266_cmd_rom.sv
// Combinational command ROM: returns byte byte_idx of command step,
// or the 0x00 end marker past the trailing CR LF.
module esp8266_cmd_rom
    import esp8266_at_sequencer_pkg::*;
(
    input  logic [2:0] step,
    input  logic [5:0] byte_idx,
    output logic [7:0] rom_byte
);

    localparam CMD0 = {"AT", CH_CR, CH_LF};
    localparam CMD1 = {"AT+CWMODE=1", CH_CR, CH_LF};
    localparam CMD2 = {"AT+CIPSTART=\"TCP\",\"10.0.0.1\",80", CH_CR, CH_LF};
    localparam CMD3 = {"AT+CIPMODE=1", CH_CR, CH_LF};
    localparam CMD4 = {"AT+CIPSEND", CH_CR, CH_LF};

    localparam int ROM_W = 8 * MAX_CMD_LEN;

    // Commands are right-aligned in a zero-extended vector; byte 0 is the MSB byte.
    function automatic logic [7:0] pick(input logic [ROM_W-1:0] cmd, input int len,
                                        input logic [5:0] idx);
        logic [7:0] b;
        if (int'(idx) < len) b = cmd[8*(len - 1 - int'(idx)) +: 8];
        else                 b = CH_END;
        return b;
    endfunction

    always_comb begin
        rom_byte = CH_END;
        case (step)
            3'd0:    rom_byte = pick(ROM_W'(CMD0), $bits(CMD0) / 8, byte_idx);
            3'd1:    rom_byte = pick(ROM_W'(CMD1), $bits(CMD1) / 8, byte_idx);
            3'd2:    rom_byte = pick(ROM_W'(CMD2), $bits(CMD2) / 8, byte_idx);
            3'd3:    rom_byte = pick(ROM_W'(CMD3), $bits(CMD3) / 8, byte_idx);
            3'd4:    rom_byte = pick(ROM_W'(CMD4), $bits(CMD4) / 8, byte_idx);
            default: rom_byte = CH_END;
        endcase
    end

endmodule

// File: rtl/esp8266_at_sequencer.sv
// Brings up an ESP8266 TCP transparent link by sending five AT commands,
// matching "OK"/"ERROR" replies with per-command timeout and retry.
module esp8266_at_sequencer
    import esp8266_at_sequencer_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TIMEOUT_MS = 2000,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       link_up,
    output logic       fail,
    output logic [2:0] step
);

    localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t          state, state_n;
    logic [2:0]      step_n;
    logic [5:0]      byte_idx, idx_n;
    logic [RW-1:0]   retry, retry_n;
    logic [31:0]     match, match_n;
    logic [TW-1:0]   timer, timer_n;
    logic            ok_seen, ok_seen_n;
    logic            tx_start_n;
    logic [7:0]      tx_data_n;
    logic [7:0]      rom_byte;
    logic [31:0]     rx_shift;
    logic            rsp_ok, rsp_err, rsp_prompt, success;

    esp8266_cmd_rom u_rom (
        .step     (step),
        .byte_idx (byte_idx),
        .rom_byte (rom_byte)
    );

    assign rx_shift   = {match[23:0], rx_data};
    assign rsp_ok     = rx_valid && (rx_shift == RSP_OK);
    assign rsp_err    = rx_valid && (rx_shift == RSP_ERR);
    // CIPSEND is only complete once the '>' prompt follows its "OK".
    assign rsp_prompt = rx_valid && (rx_data == CH_PROMPT) && ok_seen;
    assign success    = (step == LAST_STEP) ? rsp_prompt : rsp_ok;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_n    = state;
        step_n     = step;
        idx_n      = byte_idx;
        retry_n    = retry;
        match_n    = match;
        timer_n    = timer;
        ok_seen_n  = ok_seen;
        tx_start_n = 1'b0;
        tx_data_n  = tx_data;
        case (state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_n = ST_SEND;
                    step_n  = '0;
                    idx_n   = '0;
                    retry_n = '0;
                end
            end
            ST_SEND: begin
                if (rom_byte == CH_END) begin
                    state_n   = ST_WAIT_RSP;
                    match_n   = '0;
                    ok_seen_n = 1'b0;
                    timer_n   = TW'(TIMEOUT_CYC);
                end else if (!tx_busy) begin
                    tx_start_n = 1'b1;
                    tx_data_n  = rom_byte;
                    state_n    = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                // tx_start is still high in the first WAIT_TX cycle, before the UART raises busy.
                if (!tx_start && !tx_busy) begin
                    idx_n   = byte_idx + 6'd1;
                    state_n = ST_SEND;
                end
            end
            ST_WAIT_RSP: begin
                if (rx_valid) match_n = rx_shift;
                if (rsp_ok) ok_seen_n = 1'b1;
                if (success) begin
                    state_n = ST_NEXT;
                end else if (rsp_err || timer == '0) begin
                    if (int'(retry) < MAX_RETRY) begin
                        retry_n = retry + RW'(1);
                        idx_n   = '0;
                        state_n = ST_SEND;
                    end else begin
                        state_n = ST_FAIL;
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            ST_NEXT: begin
                if (step == LAST_STEP) begin
                    state_n = ST_DONE;
                end else begin
                    step_n  = step + 3'd1;
                    idx_n   = '0;
                    retry_n = '0;
                    state_n = ST_SEND;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            step     <= '0;
            byte_idx <= '0;
            retry    <= '0;
            match    <= '0;
            timer    <= '0;
            ok_seen  <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            link_up  <= 1'b0;
            fail     <= 1'b0;
        end else begin
            state    <= state_n;
            step     <= step_n;
            byte_idx <= idx_n;
            retry    <= retry_n;
            match    <= match_n;
            timer    <= timer_n;
            ok_seen  <= ok_seen_n;
            tx_start <= tx_start_n;
            tx_data  <= tx_data_n;
            link_up  <= (state_n == ST_DONE);
            fail     <= (state_n == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_esp8266_at_sequencer.sv
// Scoreboard bench: a modelled ESP8266/UART answers each command per a plan;
// the expected transmitted byte stream and final outcome come from that plan.
module tb_esp8266_at_sequencer;

    localparam int CLK_HZ     = 200_000;
    localparam int TIMEOUT_MS = 1;
    localparam int MAX_RETRY  = 3;
    localparam int NSTEP      = 5;

    typedef enum int { R_OK, R_ERR, R_SILENT } rsp_e;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       link_up;
    logic       fail;
    logic [2:0] step;

    esp8266_at_sequencer #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_MS (TIMEOUT_MS),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .link_up  (link_up),
        .fail     (fail),
        .step     (step)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    rsp_e       plan[NSTEP][MAX_RETRY+1];
    int         attempt[NSTEP];
    string      cmds[NSTEP];
    int         busy_len = 2;
    bit         echo_en = 1'b0;
    int         flush_req = 0;
    bit         exp_fail;
    int         exp_step;
    int         cyc = 0;
    int         last_pulse = -1;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_plan_all(input rsp_e r);
        for (int s = 0; s < NSTEP; s++)
            for (int a = 0; a <= MAX_RETRY; a++) plan[s][a] = r;
    endtask

    // Reference model: walk the plan command by command to predict the byte stream.
    task automatic load_scenario();
        bit stop;
        exp_q.delete();
        exp_fail = 1'b0;
        exp_step = NSTEP - 1;
        stop = 1'b0;
        for (int s = 0; s < NSTEP && !stop; s++) begin
            bit ok;
            ok = 1'b0;
            for (int a = 0; a <= MAX_RETRY && !ok; a++) begin
                for (int i = 0; i < cmds[s].len(); i++) exp_q.push_back(cmds[s][i]);
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
                if (plan[s][a] == R_OK) ok = 1'b1;
            end
            if (!ok) begin
                exp_fail = 1'b1;
                exp_step = s;
                stop     = 1'b1;
            end
        end
    endtask

    task automatic respond();
        int s, a;
        s = int'(step);
        if (s < NSTEP) begin
            a = attempt[s];
            if (attempt[s] < MAX_RETRY) attempt[s]++;
            case (plan[s][a])
                R_OK: begin
                    rx_q.push_back(8'h4F); rx_q.push_back(8'h4B);
                    rx_q.push_back(8'h0D); rx_q.push_back(8'h0A);
                    if (s == NSTEP - 1) rx_q.push_back(8'h3E);
                end
                R_ERR: begin
                    rx_q.push_back(8'h45); rx_q.push_back(8'h52); rx_q.push_back(8'h52);
                    rx_q.push_back(8'h4F); rx_q.push_back(8'h52);
                    rx_q.push_back(8'h0D); rx_q.push_back(8'h0A);
                end
                default: ;
            endcase
        end
    endtask

    // Device model: UART busy window, optional echo, reply after each CR LF.
    initial begin
        int  busy_cnt, rsp_delay, flush_seen;
        bit  rsp_pending;
        busy_cnt = 0; rsp_delay = 0; flush_seen = 0; rsp_pending = 1'b0;
        tx_busy = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        forever begin
            @(negedge clk);
            rx_valid = 1'b0;
            if (flush_req != flush_seen) begin
                flush_seen  = flush_req;
                rx_q.delete();
                busy_cnt    = 0;
                rsp_delay   = 0;
                rsp_pending = 1'b0;
                tx_busy     = 1'b0;
                for (int s = 0; s < NSTEP; s++) attempt[s] = 0;
            end else if (tx_start) begin
                tx_busy  = 1'b1;
                busy_cnt = busy_len;
                if (echo_en && step == 3'd0) rx_q.push_back(tx_data);
                if (tx_data == 8'h0A) rsp_pending = 1'b1;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    tx_busy = 1'b0;
                    if (rsp_pending) begin
                        rsp_pending = 1'b0;
                        rsp_delay   = 4;
                    end
                end
            end else if (rsp_delay > 0) begin
                rsp_delay--;
                if (rsp_delay == 0) respond();
            end
            if (rx_q.size() > 0) begin
                rx_valid = 1'b1;
                rx_data  = rx_q.pop_front();
            end
        end
    end

    // Monitor: every tx_start pulse is checked against the scoreboard queue.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                last_pulse = -1;
            end else if (tx_start) begin
                check(tx_busy == 1'b0, "tx_start_while_busy", tx_busy, 0);
                if (last_pulse >= 0)
                    check(cyc - last_pulse >= busy_len + 1, "pulse_spacing", cyc - last_pulse, busy_len + 1);
                last_pulse = cyc;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_tx", tx_data, 0);
                end else begin
                    exp_b = exp_q.pop_front();
                    check(tx_data == exp_b, "tx_byte", tx_data, exp_b);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_scenario(input string tag);
        int gap;
        load_scenario();
        flush_req++;
        pulse_start();
        gap = $urandom_range(3, 30);
        repeat (gap) @(negedge clk);
        if (!link_up && !fail) pulse_start();
        for (int c = 0; c < 40000 && !link_up && !fail; c++) @(negedge clk);
        check(link_up || fail, {tag, "_finished"}, {link_up, fail}, 1);
        repeat (30) @(negedge clk);
        check(exp_q.size() == 0, {tag, "_bytes_left"}, exp_q.size(), 0);
        check(link_up == !exp_fail, {tag, "_link_up"}, link_up, !exp_fail);
        check(fail == exp_fail, {tag, "_fail"}, fail, exp_fail);
        check(int'(step) == exp_step, {tag, "_step"}, step, exp_step);
    endtask

    initial begin
        cmds[0] = "AT";
        cmds[1] = "AT+CWMODE=1";
        cmds[2] = "AT+CIPSTART=\"TCP\",\"10.0.0.1\",80";
        cmds[3] = "AT+CIPMODE=1";
        cmds[4] = "AT+CIPSEND";
        rst   = 1'b1;
        start = 1'b0;
        set_plan_all(R_OK);
        repeat (3) @(posedge clk);
        #1;
        check(tx_start === 1'b0, "rst_tx_start", tx_start, 0);
        check(tx_data === 8'h00, "rst_tx_data", tx_data, 0);
        check(link_up === 1'b0, "rst_link_up", link_up, 0);
        check(fail === 1'b0, "rst_fail", fail, 0);
        check(step === 3'd0, "rst_step", step, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check(tx_start == 1'b0 && link_up == 1'b0, "idle_quiet", {tx_start, link_up}, 0);

        busy_len = 2;
        run_scenario("all_ok");

        set_plan_all(R_OK);
        plan[1][0] = R_ERR;
        run_scenario("step1_error_once");

        set_plan_all(R_OK);
        for (int a = 0; a <= MAX_RETRY; a++) plan[2][a] = R_SILENT;
        run_scenario("step2_timeout");

        set_plan_all(R_OK);
        echo_en = 1'b1;
        run_scenario("echo_step0");
        echo_en = 1'b0;

        busy_len = 10;
        run_scenario("slow_uart");

        // Abort in the middle of step 3 transmission.
        busy_len = 3;
        set_plan_all(R_OK);
        load_scenario();
        flush_req++;
        pulse_start();
        for (int c = 0; c < 20000 && !(step == 3'd3 && tx_busy); c++) @(negedge clk);
        check(step == 3'd3 && tx_busy, "reach_step3", step, 3);
        rst = 1'b1;
        #1;
        check(tx_start === 1'b0 && tx_data === 8'h00, "mid_rst_tx", {tx_start, tx_data}, 0);
        check(link_up === 1'b0 && fail === 1'b0, "mid_rst_flags", {link_up, fail}, 0);
        check(step === 3'd0, "mid_rst_step", step, 0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        flush_req++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check(tx_start == 1'b0, "post_rst_tx_start0", tx_start, 0);
        @(posedge clk); #1;
        check(tx_start == 1'b0, "post_rst_tx_start1", tx_start, 0);
        run_scenario("restart_after_rst");

        for (int n = 0; n < 6; n++) begin
            for (int s = 0; s < NSTEP; s++)
                for (int a = 0; a <= MAX_RETRY; a++) begin
                    int r;
                    r = $urandom_range(0, 99);
                    plan[s][a] = (r < 60) ? R_OK : (r < 85) ? R_ERR : R_SILENT;
                end
            busy_len = $urandom_range(1, 4);
            echo_en  = 1'($urandom_range(0, 1));
            run_scenario($sformatf("random%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
